// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter for the tinyrv32 fetch (i_*) and load/store (d_*) ports.
// One transaction at a time: data port has priority, with a starvation guard for fetch.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    // state | meaning
    // IDLE  | waiting for a request; arbitration decision taken here
    // ISSUE | memory command strobe, owner's gnt pulse
    // WAIT  | counting down the memory read latency
    // RESP  | owner's rvalid pulse
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]          r_state;
    logic                r_owner_d;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;
    logic [2:0]          r_lat;
    logic [3:0]          r_starve;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_any_req;
    logic w_pick_d;

    assign w_any_req = i_req | d_req;
    // Fetch only beats a pending data request once the starvation counter saturates.
    assign w_pick_d  = d_req & (~i_req | (r_starve != STARVE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_lat     <= '0;
            r_starve  <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner_d <= w_pick_d;
                        if (w_pick_d) begin
                            r_we    <= d_we;
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_be    <= d_be;
                        end else begin
                            r_we    <= 1'b0;
                            r_addr  <= i_addr;
                            r_wdata <= '0;
                            r_be    <= '1;
                        end
                        if (!i_req || !w_pick_d) begin
                            r_starve <= '0;
                        end else if (r_starve != STARVE_MAX) begin
                            r_starve <= r_starve + 4'd1;
                        end
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_lat   <= LAT_LOAD;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_lat == 3'd0) begin
                        if (!r_owner_d) begin
                            r_i_rdata <= mem_rdata;
                        end else if (!r_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                        r_state <= RESP;
                    end else begin
                        r_lat <= r_lat - 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (r_state == ISSUE);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign i_gnt     = mem_en & ~r_owner_d;
    assign d_gnt     = mem_en & r_owner_d;
    assign i_rvalid  = (r_state == RESP) & ~r_owner_d;
    assign d_rvalid  = (r_state == RESP) & r_owner_d;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A runs with MEM_LAT=2, instance B with MEM_LAT=1.
// Memory model returns addr ^ 32'hDEADBEFF only in the exact latency cycle, junk otherwise.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;

    logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_be;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_be;

    logic [32:0] a_p0, a_p1, b_p0;
    int          cyc = 0;
    int          nchk = 0;
    int          nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        a_p0 <= {a_mem_en, a_mem_addr ^ 32'hDEADBEFF};
        a_p1 <= a_p0;
        b_p0 <= {b_mem_en, b_mem_addr ^ 32'hDEADBEFF};
    end
    assign a_mem_rdata = (a_p1[32] === 1'b1) ? a_p1[31:0] : 32'hBAD0BAD0;
    assign b_mem_rdata = (b_p0[32] === 1'b1) ? b_p0[31:0] : 32'hBAD0BAD0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_LIMIT(4)) u_a (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_be(a_mem_be), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) u_b (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_be(b_mem_be), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int   w;
        int   last;
        int   ng;
        int   nr;
        logic seen;
        logic [31:0] exp_b;

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        exp_b = '0;
        repeat (2) tick;
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_mem_en", a_mem_en, 1'b0);
        chk32("rst_mem_addr", a_mem_addr, 32'h0);
        chk32("rst_mem_be", 32'(a_mem_be), 32'h0);
        chk32("rst_i_rdata", a_i_rdata, 32'h0);
        chk32("rst_d_rdata", a_d_rdata, 32'h0);
        rst = 1'b0;

        // Test 1: single fetch, MEM_LAT=2
        tick;
        chk1("t1_idle_busy", a_busy, 1'b0);
        i_req = 1'b1; i_addr = 32'h10;
        tick;
        chk1("t1_i_gnt", a_i_gnt, 1'b1);
        chk1("t1_d_gnt", a_d_gnt, 1'b0);
        chk1("t1_mem_en", a_mem_en, 1'b1);
        chk1("t1_mem_we", a_mem_we, 1'b0);
        chk32("t1_mem_addr", a_mem_addr, 32'h10);
        chk32("t1_mem_wdata", a_mem_wdata, 32'h0);
        chk32("t1_mem_be", 32'(a_mem_be), 32'hF);
        chk1("t1_busy_c1", a_busy, 1'b1);
        i_req = 1'b0;
        tick;
        chk1("t1_mem_en_c2", a_mem_en, 1'b0);
        chk1("t1_i_gnt_c2", a_i_gnt, 1'b0);
        chk1("t1_busy_c2", a_busy, 1'b1);
        tick;
        chk1("t1_rvalid_c3", a_i_rvalid, 1'b0);
        chk1("t1_busy_c3", a_busy, 1'b1);
        tick;
        chk1("t1_rvalid_c4", a_i_rvalid, 1'b1);
        chk32("t1_i_rdata", a_i_rdata, 32'hDEADBEEF);
        chk1("t1_busy_c4", a_busy, 1'b1);
        tick;
        chk1("t1_rvalid_c5", a_i_rvalid, 1'b0);
        chk1("t1_busy_c5", a_busy, 1'b0);
        chk32("t1_i_rdata_hold", a_i_rdata, 32'hDEADBEEF);
        chk32("t1_mem_addr_hold", a_mem_addr, 32'h10);

        // Test 2: simultaneous requests, data first
        i_req = 1'b1; i_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        tick;
        chk1("t2_d_gnt", a_d_gnt, 1'b1);
        chk1("t2_i_gnt", a_i_gnt, 1'b0);
        chk32("t2_mem_addr_d", a_mem_addr, 32'h40);
        d_req = 1'b0;
        repeat (3) tick;
        chk1("t2_d_rvalid", a_d_rvalid, 1'b1);
        chk1("t2_i_rvalid_early", a_i_rvalid, 1'b0);
        chk32("t2_d_rdata", a_d_rdata, 32'hDEADBEBF);
        tick;
        chk1("t2_idle_busy", a_busy, 1'b0);
        chk1("t2_idle_i_gnt", a_i_gnt, 1'b0);
        tick;
        chk1("t2_i_gnt", a_i_gnt, 1'b1);
        chk32("t2_mem_addr_i", a_mem_addr, 32'h14);
        i_req = 1'b0;
        repeat (3) tick;
        chk1("t2_i_rvalid", a_i_rvalid, 1'b1);
        chk32("t2_i_rdata", a_i_rdata, 32'hDEADBEEB);
        chk32("t2_d_rdata_hold", a_d_rdata, 32'hDEADBEBF);
        tick;
        chk1("t2_end_busy", a_busy, 1'b0);

        // Test 3: store leaves d_rdata untouched
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_be = 4'b0011;
        tick;
        chk1("t3_d_gnt", a_d_gnt, 1'b1);
        chk1("t3_mem_en", a_mem_en, 1'b1);
        chk1("t3_mem_we", a_mem_we, 1'b1);
        chk32("t3_mem_addr", a_mem_addr, 32'h20);
        chk32("t3_mem_wdata", a_mem_wdata, 32'h12345678);
        chk32("t3_mem_be", 32'(a_mem_be), 32'h3);
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_be = '0;
        tick;
        chk1("t3_mem_we_off", a_mem_we, 1'b0);
        chk1("t3_mem_en_off", a_mem_en, 1'b0);
        chk32("t3_wdata_hold", a_mem_wdata, 32'h12345678);
        chk32("t3_be_hold", 32'(a_mem_be), 32'h3);
        repeat (2) tick;
        chk1("t3_d_rvalid", a_d_rvalid, 1'b1);
        chk32("t3_d_rdata_kept", a_d_rdata, 32'hDEADBEBF);
        tick;
        chk1("t3_end_busy", a_busy, 1'b0);

        // Test 4: starvation guard, both requests held
        i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        last = 0;
        for (int k = 0; k < 10; k++) begin
            w = 0;
            while (!(a_i_gnt || a_d_gnt) && w < 20) begin
                tick;
                w++;
            end
            chk1("t4_gnt_seen", w < 20, 1'b1);
            chk1("t4_owner_is_d", a_d_gnt, (k != 4) && (k != 9));
            if (k > 0) chk32("t4_spacing", 32'(cyc - last), 32'd5);
            last = cyc;
            if (k == 9) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            tick;
        end
        w = 0;
        while (a_busy && w < 20) begin
            tick;
            w++;
        end
        chk1("t4_drain", a_busy, 1'b0);

        // Test 5: reset during WAIT
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        tick;
        chk1("t5_d_gnt", a_d_gnt, 1'b1);
        d_req = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        chk1("t5_busy", a_busy, 1'b0);
        chk1("t5_mem_en", a_mem_en, 1'b0);
        chk1("t5_d_rvalid", a_d_rvalid, 1'b0);
        chk32("t5_mem_addr", a_mem_addr, 32'h0);
        chk32("t5_mem_be", 32'(a_mem_be), 32'h0);
        chk32("t5_d_rdata", a_d_rdata, 32'h0);
        chk32("t5_i_rdata", a_i_rdata, 32'h0);
        tick;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            seen = seen | a_d_rvalid | a_i_rvalid;
        end
        chk1("t5_no_rvalid", seen, 1'b0);
        d_req = 1'b1; d_addr = 32'h84;
        tick;
        chk1("t5_regnt", a_d_gnt, 1'b1);
        d_req = 1'b0;
        repeat (3) tick;
        chk1("t5_rvalid", a_d_rvalid, 1'b1);
        chk32("t5_rdata", a_d_rdata, 32'hDEADBE7B);
        w = 0;
        while ((a_busy || b_busy) && w < 20) begin
            tick;
            w++;
        end
        chk1("t5_idle", b_busy, 1'b0);

        // Test 6: back-to-back loads on the MEM_LAT=1 instance
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        ng = 0; nr = 0; last = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (b_d_gnt) begin
                chk1("t6_mem_en", b_mem_en, 1'b1);
                if (ng > 0) chk32("t6_spacing", 32'(cyc - last), 32'd4);
                last = cyc;
                exp_b = d_addr ^ 32'hDEADBEFF;
                ng++;
                d_req = 1'b0;
            end
            if (b_d_rvalid) begin
                nr++;
                chk32("t6_rdata", b_d_rdata, exp_b);
                if (ng < 6) begin
                    d_req = 1'b1;
                    d_addr = d_addr + 32'd4;
                end
            end
        end
        chk32("t6_gnt_count", 32'(ng), 32'd6);
        chk32("t6_rvalid_count", 32'(nr), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
